// File: rtl/credit_rr_allocator.sv
// rtl/credit_rr_allocator.sv - credit-gated round-robin output allocator; optional stall counter via CRARB_STALL_CNT_EN
module credit_rr_allocator #(
  parameter int CREDITS = 4,
  parameter int CW      = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    req,
  input  logic          dn_busy,
  input  logic          credit_ret,
  output logic [3:0]    gnt,
  output logic          ena,
  output logic [CW-1:0] credits,
  output logic          ovf,
  output logic [15:0]   stall_cnt
);

  localparam logic [CW-1:0] FULL = CW'(CREDITS);

  logic [1:0] ptr;
  logic [1:0] gnt_idx;
  logic       eligible;

  // A grant is possible only with a request, an idle transmitter and a credit in hand;
  // reset masks everything so nothing leaks out while the counters are being reloaded.
  assign eligible = (|req) && !dn_busy && (credits != '0) && !reset;

  // Round-robin pick: first set request at or above ptr, wrapping from bit3 to bit0.
  always_comb begin
    logic [1:0] idx;
    logic       found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    if (eligible) begin
      for (int i = 0; i < 4; i++) begin
        idx = ptr + 2'(i);
        if (!found && req[idx]) begin
          gnt[idx] = 1'b1;
          gnt_idx  = idx;
          found    = 1'b1;
        end
      end
    end
  end

  assign ena = |gnt;

  // Priority pointer moves just past the winner so the next search starts at its neighbour.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (ena) begin
      ptr <= gnt_idx + 2'd1;
    end
  end

  // Credit bookkeeping: a grant consumes a slot, a return frees one; a return into a full
  // counter is a protocol error, so the count holds and the sticky overflow flag is raised.
  always_ff @(posedge clk) begin
    if (reset) begin
      credits <= FULL;
      ovf     <= 1'b0;
    end else if (ena && !credit_ret) begin
      credits <= credits - 1'b1;
    end else if (!ena && credit_ret) begin
      if (credits == FULL) begin
        ovf <= 1'b1;
      end else begin
        credits <= credits + 1'b1;
      end
    end
  end

`ifdef CRARB_STALL_CNT_EN
  // Count cycles lost purely to credit starvation; saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if ((|req) && !dn_busy && (credits == '0) && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_credit_rr_allocator.sv
// tb/tb_credit_rr_allocator.sv - directed vector bench for credit_rr_allocator
module tb_credit_rr_allocator;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic        dn_busy;
  logic        credit_ret;
  logic [3:0]  gnt;
  logic        ena;
  logic [3:0]  credits;
  logic        ovf;
  logic [15:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       busy;
    logic       cret;
    logic [3:0] egnt;
    logic [3:0] ecred;
    logic       eovf;
  } vec_t;

  vec_t vecs[$];

  credit_rr_allocator #(.CREDITS(4), .CW(4)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .dn_busy(dn_busy),
    .credit_ret(credit_ret),
    .gnt(gnt),
    .ena(ena),
    .credits(credits),
    .ovf(ovf),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [15:0] exp_stall;

    clk        = 1'b0;
    reset      = 1'b1;
    req        = 4'b0000;
    dn_busy    = 1'b0;
    credit_ret = 1'b0;

    //                rst  req      busy cret gnt      cred   ovf
    vecs.push_back('{1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 4'd4, 1'b0}); // reset masks grants
    vecs.push_back('{1'b0, 4'b1111, 1'b0, 1'b0, 4'b0001, 4'd3, 1'b0}); // rotation 0
    vecs.push_back('{1'b0, 4'b1111, 1'b0, 1'b0, 4'b0010, 4'd2, 1'b0}); // rotation 1
    vecs.push_back('{1'b0, 4'b1111, 1'b0, 1'b0, 4'b0100, 4'd1, 1'b0}); // rotation 2
    vecs.push_back('{1'b0, 4'b1111, 1'b0, 1'b0, 4'b1000, 4'd0, 1'b0}); // rotation 3
    vecs.push_back('{1'b0, 4'b1111, 1'b0, 1'b0, 4'b0000, 4'd0, 1'b0}); // out of credits
    vecs.push_back('{1'b0, 4'b0100, 1'b0, 1'b1, 4'b0000, 4'd1, 1'b0}); // return at zero: no grant yet
    vecs.push_back('{1'b0, 4'b0100, 1'b0, 1'b0, 4'b0100, 4'd0, 1'b0}); // granted next cycle
    vecs.push_back('{1'b0, 4'b0100, 1'b0, 1'b0, 4'b0000, 4'd0, 1'b0}); // back to starved
    vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'd1, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'd2, 1'b0});
    vecs.push_back('{1'b0, 4'b0001, 1'b0, 1'b1, 4'b0001, 4'd2, 1'b0}); // grant+return: hold, wrap 3->0
    vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'd3, 1'b0});
    vecs.push_back('{1'b0, 4'b1010, 1'b1, 1'b0, 4'b0000, 4'd3, 1'b0}); // busy blocks
    vecs.push_back('{1'b0, 4'b1010, 1'b1, 1'b0, 4'b0000, 4'd3, 1'b0}); // busy blocks
    vecs.push_back('{1'b0, 4'b1010, 1'b0, 1'b0, 4'b0010, 4'd2, 1'b0}); // ptr held at 1
    vecs.push_back('{1'b0, 4'b1010, 1'b0, 1'b0, 4'b1000, 4'd1, 1'b0});
    vecs.push_back('{1'b0, 4'b1010, 1'b0, 1'b1, 4'b0010, 4'd1, 1'b0}); // wrap to bit1, both -> hold
    vecs.push_back('{1'b0, 4'b0001, 1'b0, 1'b0, 4'b0001, 4'd0, 1'b0}); // search 2,3,0
    vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'd1, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'd2, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'd3, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'd4, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'd4, 1'b1}); // overflow at full
    vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'd4, 1'b1}); // sticky
    vecs.push_back('{1'b0, 4'b0010, 1'b0, 1'b0, 4'b0010, 4'd3, 1'b1}); // sticky through traffic
    vecs.push_back('{1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 4'd4, 1'b0}); // mid-burst reset
    vecs.push_back('{1'b0, 4'b1000, 1'b0, 1'b0, 4'b1000, 4'd3, 1'b0}); // full credits after reset
    vecs.push_back('{1'b0, 4'b1111, 1'b0, 1'b0, 4'b0001, 4'd2, 1'b0});

    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset      = vecs[i].rst;
      req        = vecs[i].req;
      dn_busy    = vecs[i].busy;
      credit_ret = vecs[i].cret;
      #1;
      check($sformatf("v%0d gnt", i), 32'(gnt), 32'(vecs[i].egnt));
      check($sformatf("v%0d ena", i), 32'(ena), 32'(|vecs[i].egnt));
      @(posedge clk);
      #1;
      check($sformatf("v%0d credits", i), 32'(credits), 32'(vecs[i].ecred));
      check($sformatf("v%0d ovf", i), 32'(ovf), 32'(vecs[i].eovf));
    end

    // Stall counter: reset, drain all credits, then starve a requester for ten cycles.
    @(negedge clk);
    reset      = 1'b1;
    req        = 4'b0000;
    dn_busy    = 1'b0;
    credit_ret = 1'b0;
    @(posedge clk);
    #1;
    check("stall after reset", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    req   = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("drain %0d gnt", k), 32'(gnt), 32'h1);
      @(negedge clk);
    end
    check("drained credits", 32'(credits), 32'd0);
    for (int k = 0; k < 10; k++) begin
      #1;
      check($sformatf("starve %0d gnt", k), 32'(gnt), 32'h0);
      @(negedge clk);
    end
`ifdef CRARB_STALL_CNT_EN
    exp_stall = 16'd10;
`else
    exp_stall = 16'd0;
`endif
    check("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    req = 4'b0000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
